// File: rtl/fft_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter: round-robin pick
// function and owner-tag width derivation.
package fft_arb_pkg;

   localparam int MAX_REQ = 8;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // A single requester still needs a one-bit owner tag.
   function automatic int tag_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                     input logic [2:0]         prio,
                                     input int unsigned        n);
      pick_t       r;
      int unsigned k;
      r = '0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         k = (32'(prio) + i) % n;
         if (i < n && !r.found && valid[k[2:0]]) begin
            r.found = 1'b1;
            r.idx   = k[2:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_mult_comp.sv
// Pipelined complex multiplier: data times coefficient, coefficient unity
// is 2^(W_BIT-2), result truncated back to D_BIT after MULT_LAT registers.
module fft_mult_comp #(
   parameter int D_BIT    = 17,
   parameter int W_BIT    = 12,
   parameter int MULT_LAT = 1
) (
   input  logic             iCLK,
   input  logic [D_BIT-1:0] iRE,
   input  logic [D_BIT-1:0] iIM,
   input  logic [W_BIT-1:0] iW_RE,
   input  logic [W_BIT-1:0] iW_IM,
   output logic [D_BIT-1:0] oRE,
   output logic [D_BIT-1:0] oIM
);
   localparam int PW = D_BIT + W_BIT;

   logic signed [PW-1:0] pRr, pIi, pRi, pIr;
   logic signed [PW:0]   sumRe, sumIm, shRe, shIm;
   logic [D_BIT-1:0]     re_q [MULT_LAT];
   logic [D_BIT-1:0]     im_q [MULT_LAT];

   assign pRr   = $signed(iRE) * $signed(iW_RE);
   assign pIi   = $signed(iIM) * $signed(iW_IM);
   assign pRi   = $signed(iRE) * $signed(iW_IM);
   assign pIr   = $signed(iIM) * $signed(iW_RE);
   assign sumRe = {pRr[PW-1], pRr} - {pIi[PW-1], pIi};
   assign sumIm = {pRi[PW-1], pRi} + {pIr[PW-1], pIr};
   assign shRe  = sumRe >>> (W_BIT - 2);
   assign shIm  = sumIm >>> (W_BIT - 2);

   always_ff @(posedge iCLK) begin
      re_q[0] <= shRe[D_BIT-1:0];
      im_q[0] <= shIm[D_BIT-1:0];
      for (int i = 1; i < MULT_LAT; i++) begin
         re_q[i] <= re_q[i-1];
         im_q[i] <= im_q[i-1];
      end
   end

   assign oRE = re_q[MULT_LAT-1];
   assign oIM = im_q[MULT_LAT-1];

endmodule

// File: rtl/fft_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after prio.
module fft_rr_pick
   import fft_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int TAG_W = tag_width(N_REQ)
) (
   input  logic [N_REQ-1:0] valid_i,
   input  logic [TAG_W-1:0] prio_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [TAG_W-1:0] idx_o,
   output logic             found_o
);
   pick_t pick;

   assign pick    = rr_pick(MAX_REQ'(valid_i), 3'(prio_i), N_REQ);
   assign found_o = pick.found;
   assign idx_o   = TAG_W'(pick.idx);
   assign grant_o = pick.found ? (N_REQ'(1) << pick.idx) : '0;

endmodule

// File: rtl/fft_mult_arb.sv
// Round-robin arbiter sharing one complex multiplier between FFT butterflies;
// tracks product ownership through the multiplier pipeline.
module fft_mult_arb
   import fft_arb_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int D_BIT    = 17,
   parameter int W_BIT    = 12,
   parameter int MULT_LAT = 1
) (
   input  logic                   iCLK,
   input  logic                   iRESET,
   input  logic [N_REQ-1:0]       iREQ_VALID,
   output logic [N_REQ-1:0]       oREQ_READY,
   input  logic [N_REQ*D_BIT-1:0] iRE,
   input  logic [N_REQ*D_BIT-1:0] iIM,
   input  logic [N_REQ*W_BIT-1:0] iW_RE,
   input  logic [N_REQ*W_BIT-1:0] iW_IM,
   output logic [D_BIT-1:0]       oM_RE,
   output logic [D_BIT-1:0]       oM_IM,
   output logic [W_BIT-1:0]       oM_W_RE,
   output logic [W_BIT-1:0]       oM_W_IM,
   input  logic [D_BIT-1:0]       iM_RE,
   input  logic [D_BIT-1:0]       iM_IM,
   output logic [N_REQ-1:0]       oRES_VALID,
   output logic [D_BIT-1:0]       oRES_RE,
   output logic [D_BIT-1:0]       oRES_IM,
   input  logic                   iFLUSH,
   output logic                   oIDLE
);
   localparam int TAG_W  = tag_width(N_REQ);
   localparam int STAGES = MULT_LAT + 1;
   localparam int CNT_W  = $clog2(MULT_LAT + 2);

   logic [N_REQ-1:0]  pickGrant;
   logic [TAG_W-1:0]  pickIdx;
   logic              pickFound;
   logic              xfer;
   logic              resValid;
   logic [TAG_W-1:0]  prio_q, prio_d;
   logic [STAGES-1:0] vld_q;
   logic [TAG_W-1:0]  tag_q [STAGES];
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   fft_rr_pick #(.N_REQ(N_REQ), .TAG_W(TAG_W)) uPick (
      .valid_i (iREQ_VALID),
      .prio_i  (prio_q),
      .grant_o (pickGrant),
      .idx_o   (pickIdx),
      .found_o (pickFound)
   );

   // Reset also blocks grants so nothing is accepted that the reset would lose.
   assign xfer       = pickFound & ~iFLUSH & ~iRESET;
   assign oREQ_READY = xfer ? pickGrant : '0;
   assign resValid   = vld_q[STAGES-1];

   always_comb begin
      prio_d = prio_q;
      if (xfer) begin
         prio_d = (pickIdx == TAG_W'(N_REQ - 1)) ? '0 : pickIdx + TAG_W'(1);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({xfer, resValid})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         prio_q  <= '0;
         cnt_q   <= '0;
         vld_q   <= '0;
         oM_RE   <= '0;
         oM_IM   <= '0;
         oM_W_RE <= '0;
         oM_W_IM <= '0;
      end else begin
         prio_q <= prio_d;
         cnt_q  <= cnt_d;
         vld_q  <= {vld_q[STAGES-2:0], xfer};
         if (xfer) begin
            oM_RE   <= iRE[pickIdx*D_BIT +: D_BIT];
            oM_IM   <= iIM[pickIdx*D_BIT +: D_BIT];
            oM_W_RE <= iW_RE[pickIdx*W_BIT +: W_BIT];
            oM_W_IM <= iW_IM[pickIdx*W_BIT +: W_BIT];
         end
      end
   end

   // Owner tags need no reset: they are only observed behind a valid bit.
   always_ff @(posedge iCLK) begin
      tag_q[0] <= pickIdx;
      for (int i = 1; i < STAGES; i++) begin
         tag_q[i] <= tag_q[i-1];
      end
   end

   assign oRES_VALID = resValid ? (N_REQ'(1) << tag_q[STAGES-1]) : '0;
   assign oRES_RE    = resValid ? iM_RE : '0;
   assign oRES_IM    = resValid ? iM_IM : '0;
   assign oIDLE      = (cnt_q == '0) & ~xfer;

endmodule
